// File: rtl/apb_bridge_pkg.sv
// ---------------------------------------------------------------------------
// apb_bridge_pkg
// Shared definitions for the APB master controller:
//   - apb_state_t : controller FSM states
//   - REGIONn_BASE / REGIONn_LIMIT : inclusive address windows of the three
//     APB slaves
//   - SEL_* : one-hot Pselx encodings that go with each window
// ---------------------------------------------------------------------------
package apb_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ENABLE = 2'd2,
    ST_ERR    = 2'd3
  } apb_state_t;

  localparam logic [31:0] REGION0_BASE  = 32'h8000_0000;
  localparam logic [31:0] REGION0_LIMIT = 32'h83FF_FFFF;
  localparam logic [31:0] REGION1_BASE  = 32'h8400_0000;
  localparam logic [31:0] REGION1_LIMIT = 32'h87FF_FFFF;
  localparam logic [31:0] REGION2_BASE  = 32'h8800_0000;
  localparam logic [31:0] REGION2_LIMIT = 32'h8BFF_FFFF;

  localparam logic [2:0] SEL_NONE    = 3'b000;
  localparam logic [2:0] SEL_REGION0 = 3'b001;
  localparam logic [2:0] SEL_REGION1 = 3'b010;
  localparam logic [2:0] SEL_REGION2 = 3'b100;

endpackage

// File: rtl/apb_addr_decode.sv
// ---------------------------------------------------------------------------
// apb_addr_decode
// Purely combinational address decoder for the three APB slave windows.
// Ports:
//   addr  in  [31:0]  address to decode
//   sel   out [2:0]   one-hot slave select (000 when unmapped)
//   valid out         1 when addr falls inside one of the windows
// ---------------------------------------------------------------------------
module apb_addr_decode
  import apb_bridge_pkg::*;
(
  input  logic [31:0] addr,
  output logic [2:0]  sel,
  output logic        valid
);

  // Windows do not overlap, so the priority order here is irrelevant.
  always_comb begin
    sel   = SEL_NONE;
    valid = 1'b0;
    if (addr >= REGION0_BASE && addr <= REGION0_LIMIT) begin
      sel   = SEL_REGION0;
      valid = 1'b1;
    end else if (addr >= REGION1_BASE && addr <= REGION1_LIMIT) begin
      sel   = SEL_REGION1;
      valid = 1'b1;
    end else if (addr >= REGION2_BASE && addr <= REGION2_LIMIT) begin
      sel   = SEL_REGION2;
      valid = 1'b1;
    end
  end

endmodule

// File: rtl/apb_master_ctrl.sv
// ---------------------------------------------------------------------------
// apb_master_ctrl
// Turns single upstream requests into APB SETUP/ENABLE transfers, with an
// error path for unmapped addresses that completes with the same latency.
// Ports:
//   Hclk, Hreset           clock, synchronous active-high reset
//   req_valid/req_ready    upstream handshake
//   req_write/addr/wdata   request payload
//   rsp_valid/err/rdata    one-cycle completion (rdata holds until next one)
//   Pselx, Penable, Pwrite APB control
//   Paddr, Pwdata, Prdata  APB address and data
// ---------------------------------------------------------------------------
module apb_master_ctrl
  import apb_bridge_pkg::*;
(
  input  logic        Hclk,
  input  logic        Hreset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic        rsp_err,
  output logic [31:0] rsp_rdata,
  output logic        Pwrite,
  output logic        Penable,
  output logic [2:0]  Pselx,
  output logic [31:0] Paddr,
  output logic [31:0] Pwdata,
  input  logic [31:0] Prdata
);

  apb_state_t  state_q, state_d;
  logic        accept;
  logic [2:0]  dec_sel;
  logic        dec_valid;
  logic        write_q;
  logic [31:0] addr_q, wdata_q;
  logic [2:0]  sel_q;
  // Delays the error completion by one cycle so it lands at the same
  // offset after accept as a mapped completion does.
  logic        err_pend_q;

  apb_addr_decode u_decode (
    .addr  (req_addr),
    .sel   (dec_sel),
    .valid (dec_valid)
  );

  // State register
  always_ff @(posedge Hclk) begin
    if (Hreset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic and APB control outputs. req_ready is forced low
  // during reset so nothing can be captured on the reset edge.
  always_comb begin
    req_ready = 1'b0;
    state_d   = ST_IDLE;
    Pselx     = SEL_NONE;
    Penable   = 1'b0;
    if (!Hreset && state_q != ST_SETUP) req_ready = 1'b1;
    accept = req_valid & req_ready;
    case (state_q)
      ST_SETUP: begin
        Pselx   = sel_q;
        state_d = ST_ENABLE;
      end
      ST_ENABLE: begin
        Pselx   = sel_q;
        Penable = 1'b1;
      end
      default: ;
    endcase
    if (state_q != ST_SETUP) begin
      if (accept) state_d = dec_valid ? ST_SETUP : ST_ERR;
      else        state_d = ST_IDLE;
    end
  end

  // Request capture; the APB address/data lines hold these between transfers.
  always_ff @(posedge Hclk) begin
    if (Hreset) begin
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      sel_q   <= SEL_NONE;
    end else if (accept) begin
      write_q <= req_write;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      sel_q   <= dec_sel;
    end
  end

  assign Pwrite = write_q;
  assign Paddr  = addr_q;
  assign Pwdata = wdata_q;

  // Completion pipeline. An ENABLE cycle and a pending error can never
  // coincide (ERR is never directly followed by ENABLE), so responses
  // stay one cycle wide and in order.
  always_ff @(posedge Hclk) begin
    if (Hreset) begin
      err_pend_q <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_err    <= 1'b0;
      rsp_rdata  <= '0;
    end else begin
      err_pend_q <= (state_q == ST_ERR);
      if (state_q == ST_ENABLE) begin
        rsp_valid <= 1'b1;
        rsp_err   <= 1'b0;
        rsp_rdata <= write_q ? 32'h0 : Prdata;
      end else if (err_pend_q) begin
        rsp_valid <= 1'b1;
        rsp_err   <= 1'b1;
        rsp_rdata <= 32'h0;
      end else begin
        rsp_valid <= 1'b0;
        rsp_err   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_apb_master_ctrl.sv
// ---------------------------------------------------------------------------
// tb_apb_master_ctrl
// Cycle-by-cycle directed vectors for apb_master_ctrl: each row gives the
// inputs for one clock cycle and the outputs expected during that cycle.
// A short hand-written sequence then measures mapped read latency.
// ---------------------------------------------------------------------------
module tb_apb_master_ctrl;

  logic        Hclk = 1'b0;
  logic        Hreset;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        Pwrite, Penable;
  logic [2:0]  Pselx;
  logic [31:0] Paddr, Pwdata, Prdata;

  int checks   = 0;
  int failures = 0;

  apb_master_ctrl dut (
    .Hclk      (Hclk),
    .Hreset    (Hreset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_err   (rsp_err),
    .rsp_rdata (rsp_rdata),
    .Pwrite    (Pwrite),
    .Penable   (Penable),
    .Pselx     (Pselx),
    .Paddr     (Paddr),
    .Pwdata    (Pwdata),
    .Prdata    (Prdata)
  );

  always #5 Hclk = ~Hclk;

  typedef struct {
    logic        rst, valid, write;
    logic [31:0] addr, wdata, prdata;
    logic        ready;
    logic [2:0]  sel;
    logic        pen, pwrite;
    logic [31:0] paddr, pwdata;
    logic        rv, rerr;
    logic [31:0] rdata;
  } vec_t;

  localparam int NV = 35;
  vec_t vecs[NV];

  function automatic vec_t mk(logic rst, logic valid, logic write,
                              logic [31:0] addr, logic [31:0] wdata,
                              logic [31:0] prdata, logic ready, logic [2:0] sel,
                              logic pen, logic pwrite, logic [31:0] paddr,
                              logic [31:0] pwdata, logic rv, logic rerr,
                              logic [31:0] rdata);
    vec_t v;
    v.rst = rst; v.valid = valid; v.write = write;
    v.addr = addr; v.wdata = wdata; v.prdata = prdata;
    v.ready = ready; v.sel = sel; v.pen = pen; v.pwrite = pwrite;
    v.paddr = paddr; v.pwdata = pwdata;
    v.rv = rv; v.rerr = rerr; v.rdata = rdata;
    return v;
  endfunction

  // Drive one row's inputs (blocking, just after the rising edge)
  task automatic applyStimulus(input vec_t v);
    Hreset    = v.rst;
    req_valid = v.valid;
    req_write = v.write;
    req_addr  = v.addr;
    req_wdata = v.wdata;
    Prdata    = v.prdata;
  endtask

  task automatic checkOutput(input string name, input int row,
                             input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL row %0d %s: got %h expected %h", row, name, act, exp);
    end
  endtask

  task automatic checkRow(input int row, input vec_t v);
    checkOutput("req_ready", row, {31'b0, req_ready}, {31'b0, v.ready});
    checkOutput("Pselx",     row, {29'b0, Pselx},     {29'b0, v.sel});
    checkOutput("Penable",   row, {31'b0, Penable},   {31'b0, v.pen});
    checkOutput("Pwrite",    row, {31'b0, Pwrite},    {31'b0, v.pwrite});
    checkOutput("Paddr",     row, Paddr,              v.paddr);
    checkOutput("Pwdata",    row, Pwdata,             v.pwdata);
    checkOutput("rsp_valid", row, {31'b0, rsp_valid}, {31'b0, v.rv});
    checkOutput("rsp_err",   row, {31'b0, rsp_err},   {31'b0, v.rerr});
    checkOutput("rsp_rdata", row, rsp_rdata,          v.rdata);
  endtask

  initial begin
    int n;
    //            rst v w addr          wdata         prdata       rdy sel    pen pw paddr         pwdata        rv re rdata
    vecs[0]  = mk(1,0,0,32'h0,          32'h0,        32'h0,        0,3'b000,0,0,32'h0,        32'h0,        0,0,32'h0);
    vecs[1]  = mk(0,1,0,32'h8000_0010,  32'h0,        32'h0,        1,3'b000,0,0,32'h0,        32'h0,        0,0,32'h0);
    vecs[2]  = mk(0,0,0,32'h0,          32'h0,        32'h0,        0,3'b001,0,0,32'h8000_0010,32'h0,        0,0,32'h0);
    vecs[3]  = mk(0,0,0,32'h0,          32'h0,        32'hA5,       1,3'b001,1,0,32'h8000_0010,32'h0,        0,0,32'h0);
    vecs[4]  = mk(0,1,1,32'h8800_0004,  32'hDEADBEEF, 32'h0,        1,3'b000,0,0,32'h8000_0010,32'h0,        1,0,32'hA5);
    vecs[5]  = mk(0,0,0,32'h0,          32'h0,        32'h0,        0,3'b100,0,1,32'h8800_0004,32'hDEADBEEF, 0,0,32'hA5);
    vecs[6]  = mk(0,0,0,32'h0,          32'h0,        32'h12345678, 1,3'b100,1,1,32'h8800_0004,32'hDEADBEEF, 0,0,32'hA5);
    vecs[7]  = mk(0,1,0,32'h9000_0000,  32'h0,        32'h0,        1,3'b000,0,1,32'h8800_0004,32'hDEADBEEF, 1,0,32'h0);
    vecs[8]  = mk(0,0,0,32'h0,          32'h0,        32'h0,        1,3'b000,0,0,32'h9000_0000,32'h0,        0,0,32'h0);
    vecs[9]  = mk(0,0,0,32'h0,          32'h0,        32'h0,        1,3'b000,0,0,32'h9000_0000,32'h0,        0,0,32'h0);
    vecs[10] = mk(0,1,1,32'h8400_0000,  32'h11112222, 32'h0,        1,3'b000,0,0,32'h9000_0000,32'h0,        1,1,32'h0);
    vecs[11] = mk(0,1,1,32'h8400_0000,  32'h11112222, 32'h0,        0,3'b010,0,1,32'h8400_0000,32'h11112222, 0,0,32'h0);
    vecs[12] = mk(0,1,0,32'h8000_0000,  32'h0,        32'h0,        1,3'b010,1,1,32'h8400_0000,32'h11112222, 0,0,32'h0);
    vecs[13] = mk(0,1,0,32'h8000_0000,  32'h0,        32'h0,        0,3'b001,0,0,32'h8000_0000,32'h0,        1,0,32'h0);
    vecs[14] = mk(0,0,0,32'h0,          32'h0,        32'hCAFE0001, 1,3'b001,1,0,32'h8000_0000,32'h0,        0,0,32'h0);
    vecs[15] = mk(0,1,0,32'h0000_0100,  32'h0,        32'h0,        1,3'b000,0,0,32'h8000_0000,32'h0,        1,0,32'hCAFE0001);
    vecs[16] = mk(0,1,0,32'h8400_0040,  32'h0,        32'h0,        1,3'b000,0,0,32'h0000_0100,32'h0,        0,0,32'hCAFE0001);
    vecs[17] = mk(0,0,0,32'h0,          32'h0,        32'h0,        0,3'b010,0,0,32'h8400_0040,32'h0,        0,0,32'hCAFE0001);
    vecs[18] = mk(0,0,0,32'h0,          32'h0,        32'h5A5A5A5A, 1,3'b010,1,0,32'h8400_0040,32'h0,        1,1,32'h0);
    vecs[19] = mk(0,1,1,32'h8000_0008,  32'h77,       32'h0,        1,3'b000,0,0,32'h8400_0040,32'h0,        1,0,32'h5A5A5A5A);
    vecs[20] = mk(0,0,0,32'h0,          32'h0,        32'h0,        0,3'b001,0,1,32'h8000_0008,32'h77,       0,0,32'h5A5A5A5A);
    vecs[21] = mk(1,1,0,32'h9000_0000,  32'h0,        32'hFFFFFFFF, 0,3'b001,1,1,32'h8000_0008,32'h77,       0,0,32'h5A5A5A5A);
    vecs[22] = mk(0,0,0,32'h0,          32'h0,        32'h0,        1,3'b000,0,0,32'h0,        32'h0,        0,0,32'h0);
    vecs[23] = mk(0,0,0,32'h0,          32'h0,        32'h0,        1,3'b000,0,0,32'h0,        32'h0,        0,0,32'h0);
    vecs[24] = mk(0,0,0,32'h0,          32'h0,        32'h0,        1,3'b000,0,0,32'h0,        32'h0,        0,0,32'h0);
    vecs[25] = mk(0,1,0,32'h83FF_FFFF,  32'h0,        32'h0,        1,3'b000,0,0,32'h0,        32'h0,        0,0,32'h0);
    vecs[26] = mk(0,0,0,32'h0,          32'h0,        32'h0,        0,3'b001,0,0,32'h83FF_FFFF,32'h0,        0,0,32'h0);
    vecs[27] = mk(0,1,0,32'h8BFF_FFFF,  32'h0,        32'h1,        1,3'b001,1,0,32'h83FF_FFFF,32'h0,        0,0,32'h0);
    vecs[28] = mk(0,0,0,32'h0,          32'h0,        32'h0,        0,3'b100,0,0,32'h8BFF_FFFF,32'h0,        1,0,32'h1);
    vecs[29] = mk(0,1,0,32'h8C00_0000,  32'h0,        32'h2,        1,3'b100,1,0,32'h8BFF_FFFF,32'h0,        0,0,32'h1);
    vecs[30] = mk(0,1,0,32'h7FFF_FFFF,  32'h0,        32'h0,        1,3'b000,0,0,32'h8C00_0000,32'h0,        1,0,32'h2);
    vecs[31] = mk(0,0,0,32'h0,          32'h0,        32'h0,        1,3'b000,0,0,32'h7FFF_FFFF,32'h0,        0,0,32'h2);
    vecs[32] = mk(0,0,0,32'h0,          32'h0,        32'h0,        1,3'b000,0,0,32'h7FFF_FFFF,32'h0,        1,1,32'h0);
    vecs[33] = mk(0,0,0,32'h0,          32'h0,        32'h0,        1,3'b000,0,0,32'h7FFF_FFFF,32'h0,        1,1,32'h0);
    vecs[34] = mk(0,0,0,32'h0,          32'h0,        32'h0,        1,3'b000,0,0,32'h7FFF_FFFF,32'h0,        0,0,32'h0);

    // Preamble: hold reset across two edges before the table starts
    applyStimulus(vecs[0]);
    repeat (2) @(posedge Hclk);

    for (int i = 0; i < NV; i++) begin
      #1;
      applyStimulus(vecs[i]);
      @(negedge Hclk);
      checkRow(i, vecs[i]);
      @(posedge Hclk);
    end

    // Hand-written latency check: mapped read accepted in IDLE should
    // complete exactly three cycles later with the sampled Prdata.
    #1;
    req_valid = 1'b1; req_write = 1'b0;
    req_addr  = 32'h8400_0010; req_wdata = 32'h0; Prdata = 32'h0;
    @(negedge Hclk);
    checkOutput("lat_ready", 100, {31'b0, req_ready}, 32'h1);
    @(posedge Hclk);
    #1;
    req_valid = 1'b0; Prdata = 32'h0000_ABCD;
    n = 1;
    while (n < 10) begin
      @(negedge Hclk);
      if (rsp_valid) break;
      @(posedge Hclk);
      #1;
      n++;
    end
    checkOutput("lat_cycles", 100, n, 32'd3);
    checkOutput("lat_rdata",  100, rsp_rdata, 32'h0000_ABCD);
    checkOutput("lat_err",    100, {31'b0, rsp_err}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
